// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_sequencer_pkg
// Shared definitions for the staged peripheral reset sequencer:
//   - FSM state encoding
//   - CSR register offsets relative to the block base address
//   - CSR bit positions
//   - small helpers for delay clamping and the legal hold-mask bits
// No ports; imported by reset_sequencer and stage_timer.
// -----------------------------------------------------------------------------
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Register offsets from BASE_ADDR
    localparam logic [4:0] OFF_CTRL  = 5'd0;
    localparam logic [4:0] OFF_DELAY = 5'd1;
    localparam logic [4:0] OFF_CMD   = 5'd2;

    // Bit positions
    localparam int CTRL_DONE_BIT   = 7;
    localparam int CTRL_BUSY_BIT   = 6;
    localparam int CMD_RESTART_BIT = 0;

    // A programmed delay of zero would never expire; it behaves as one tick.
    function automatic logic [7:0] clamp_delay(input logic [7:0] d);
        logic [7:0] r;
        if (d == 8'd0) begin
            r = 8'd1;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Hold bits that map onto real stages; higher bits read 0 and drop writes.
    function automatic logic [5:0] hold_mask(input int n);
        logic [5:0] m;
        m = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/reset_sequencer_stage_timer.sv
// -----------------------------------------------------------------------------
// stage_timer
// ce-gated 8-bit tick counter that measures the spacing between stage
// releases. The period is captured on load (zero clamped to one) and the
// counter restarts from zero after every expiry.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   ce        single-cycle tick enable
//   run       count ce ticks while high
//   clear     force count to zero (period kept)
//   load      capture load_val as the period and zero the count
//   load_val  period in ce ticks
//   expire    one-cycle pulse on the ce tick that completes a period
// -----------------------------------------------------------------------------
module stage_timer
    import reset_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] cnt_r;
    logic [7:0] period_r;
    logic       expire_s;

    // Expiry: the tick being counted now brings cnt+1 up to the period.
    always_comb begin
        expire_s = 1'b0;
        if (run && ce && (({1'b0, cnt_r} + 9'd1) == {1'b0, period_r})) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Counter and period registers; load beats clear beats counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= 8'd0;
            period_r <= 8'd1;
        end else if (load) begin
            cnt_r    <= 8'd0;
            period_r <= clamp_delay(load_val);
        end else if (clear) begin
            cnt_r    <= 8'd0;
            period_r <= period_r;
        end else if (run && ce) begin
            if (expire_s) begin
                cnt_r <= 8'd0;
            end else begin
                cnt_r <= cnt_r + 8'd1;
            end
            period_r <= period_r;
        end else begin
            cnt_r    <= cnt_r;
            period_r <= period_r;
        end
    end

    assign expire = expire_s;

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Staged peripheral reset sequencer on the shared CSR bus. After a start
// pulse with power good, releases NUM_STAGES active-high resets one by one,
// spaced by DELAY ce ticks. Software may hold stages, read progress and
// restart the sequence.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   ce        single-cycle tick enable
//   csr_a     CSR address
//   csr_di    CSR write data
//   csr_we    CSR write strobe
//   csr_do    CSR read data, 8'h00 outside BASE_ADDR..BASE_ADDR+2 (OR-bus)
//   start     single-cycle pulse that begins the sequence
//   pwr_good  low aborts and holds all stages in reset
//   rst_out   per-stage active-high reset, registered
//   done      high while the sequence is complete
// Registers:
//   +0 CTRL  [7] done RO, [6] busy RO, [5:0] hold mask RW
//   +1 DELAY ticks between releases (0 acts as 1)
//   +2 CMD   write bit0=1 restarts; reads {5'b0, idx}
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR     = 5'h0,
    parameter int         NUM_STAGES    = 4,
    parameter logic [7:0] DEFAULT_DELAY = 8'h10,
    parameter logic [5:0] DEFAULT_HOLD  = 6'b000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [4:0]            csr_a,
    input  logic [7:0]            csr_di,
    input  logic                  csr_we,
    output logic [7:0]            csr_do,
    input  logic                  start,
    input  logic                  pwr_good,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  done
);

    localparam logic [4:0] ADDR_CTRL  = BASE_ADDR + OFF_CTRL;
    localparam logic [4:0] ADDR_DELAY = BASE_ADDR + OFF_DELAY;
    localparam logic [4:0] ADDR_CMD   = BASE_ADDR + OFF_CMD;
    localparam logic [5:0] HOLD_MASK  = hold_mask(NUM_STAGES);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_STAGES - 1);

    seq_state_t            state_r, state_s;
    logic [2:0]            idx_r, idx_s;
    logic [NUM_STAGES-1:0] released_r, released_s;
    logic [NUM_STAGES-1:0] rst_out_r;
    logic [5:0]            hold_r;
    logic [7:0]            delay_r;
    logic [7:0]            csr_do_s;
    logic [7:0]            ctrl_s;

    logic wr_ctrl_s;
    logic wr_delay_s;
    logic restart_s;
    logic t_run_s;
    logic t_clear_s;
    logic t_load_s;
    logic t_expire_s;

    assign wr_ctrl_s  = csr_we && (csr_a == ADDR_CTRL);
    assign wr_delay_s = csr_we && (csr_a == ADDR_DELAY);
    assign restart_s  = csr_we && (csr_a == ADDR_CMD) && csr_di[CMD_RESTART_BIT];

    stage_timer u_stage_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .run      (t_run_s),
        .clear    (t_clear_s),
        .load     (t_load_s),
        .load_val (delay_r),
        .expire   (t_expire_s)
    );

    // Next-state logic: pwr_good low, then restart, then per-state behaviour.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        released_s = released_r;
        t_run_s    = 1'b0;
        t_clear_s  = 1'b0;
        t_load_s   = 1'b0;
        if (!pwr_good) begin
            state_s    = ST_IDLE;
            idx_s      = 3'd0;
            released_s = '0;
            t_clear_s  = 1'b1;
        end else if (restart_s && (state_r != ST_IDLE)) begin
            // Restart preempts any tick arriving in the same cycle.
            state_s    = ST_WAIT;
            idx_s      = 3'd0;
            released_s = '0;
            t_load_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idx_s      = 3'd0;
                    released_s = '0;
                    if (start) begin
                        state_s  = ST_WAIT;
                        t_load_s = 1'b1;
                    end else begin
                        state_s   = ST_IDLE;
                        t_clear_s = 1'b1;
                    end
                end
                ST_WAIT: begin
                    t_run_s = 1'b1;
                    if (t_expire_s) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (idx_r == 3'(i)) begin
                                released_s[i] = 1'b1;
                            end else begin
                                released_s[i] = released_r[i];
                            end
                        end
                        // idx stays on the last stage once the sequence completes.
                        if (idx_r == LAST_IDX) begin
                            state_s = ST_DONE;
                        end else begin
                            idx_s = idx_r + 3'd1;
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_s    = ST_DONE;
                    released_s = '1;
                end
                default: begin
                    state_s    = ST_IDLE;
                    idx_s      = 3'd0;
                    released_s = '0;
                    t_clear_s  = 1'b1;
                end
            endcase
        end
    end

    // FSM state, stage index and release set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= 3'd0;
            released_r <= '0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            released_r <= released_s;
        end
    end

    // Software-visible DELAY and hold mask registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delay_r <= DEFAULT_DELAY;
            hold_r  <= DEFAULT_HOLD & HOLD_MASK;
        end else begin
            if (wr_delay_s) begin
                delay_r <= csr_di;
            end else begin
                delay_r <= delay_r;
            end
            if (wr_ctrl_s) begin
                hold_r <= csr_di[5:0] & HOLD_MASK;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Reset pins: a stage is in reset until released, or whenever held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_out_r <= '1;
        end else begin
            rst_out_r <= ~released_r | hold_r[NUM_STAGES-1:0];
        end
    end

    // CTRL read value assembled from status and hold mask.
    always_comb begin
        ctrl_s                = 8'h00;
        ctrl_s[5:0]           = hold_r;
        ctrl_s[CTRL_DONE_BIT] = (state_r == ST_DONE);
        ctrl_s[CTRL_BUSY_BIT] = (state_r == ST_WAIT);
    end

    // CSR read mux; zero outside our window so the bus can be OR-combined.
    always_comb begin
        csr_do_s = 8'h00;
        if (csr_a == ADDR_CTRL) begin
            csr_do_s = ctrl_s;
        end else if (csr_a == ADDR_DELAY) begin
            csr_do_s = delay_r;
        end else if (csr_a == ADDR_CMD) begin
            csr_do_s = {5'b00000, idx_r};
        end else begin
            csr_do_s = 8'h00;
        end
    end

    assign csr_do  = csr_do_s;
    assign rst_out = rst_out_r;
    assign done    = (state_r == ST_DONE);

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer (NUM_STAGES=4, BASE_ADDR=0): a vector
// table for the basic sequence and a restart, then hand-written sequences
// for hold, power loss, zero delay, ignored start and restart/tick priority.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic [4:0]    csr_a;
    logic [7:0]    csr_di;
    logic          csr_we;
    logic [7:0]    csr_do;
    logic          start;
    logic          pwr_good;
    logic [NS-1:0] rst_out;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .BASE_ADDR     (5'h0),
        .NUM_STAGES    (NS),
        .DEFAULT_DELAY (8'h10),
        .DEFAULT_HOLD  (6'b000000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .csr_a    (csr_a),
        .csr_di   (csr_di),
        .csr_we   (csr_we),
        .csr_do   (csr_do),
        .start    (start),
        .pwr_good (pwr_good),
        .rst_out  (rst_out),
        .done     (done)
    );

    typedef struct {
        logic       ce;
        logic       start;
        logic       we;
        logic [4:0] a;
        logic [7:0] di;
        logic [3:0] rst;
        logic       done;
        logic [7:0] dout;
    } vec_t;

    vec_t vt[19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [7:0] exp);
        csr_a = a;
        #1;
        chk(name, csr_do, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_we = 1'b1;
        csr_a  = a;
        csr_di = d;
        step();
        csr_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        //          ce    start we    a      di     rst    done  dout
        vt[0]  = '{1'b0, 1'b0, 1'b1, 5'd1, 8'h02, 4'hF, 1'b0, 8'h02};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 4'hF, 1'b0, 8'h40};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'hF, 1'b0, 8'h40};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 5'd2, 8'h00, 4'hF, 1'b0, 8'h01};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 5'd2, 8'h00, 4'hE, 1'b0, 8'h01};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 5'd2, 8'h00, 4'hE, 1'b0, 8'h01};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 5'd2, 8'h00, 4'hE, 1'b0, 8'h02};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'hC, 1'b0, 8'h40};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'hC, 1'b0, 8'h40};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'h8, 1'b0, 8'h40};
        vt[10] = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'h8, 1'b1, 8'h80};
        vt[11] = '{1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 4'h0, 1'b1, 8'h80};
        vt[12] = '{1'b0, 1'b0, 1'b1, 5'd1, 8'h01, 4'h0, 1'b1, 8'h01};
        vt[13] = '{1'b0, 1'b0, 1'b1, 5'd2, 8'h01, 4'h0, 1'b0, 8'h00};
        vt[14] = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'hF, 1'b0, 8'h40};
        vt[15] = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'hE, 1'b0, 8'h40};
        vt[16] = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'hC, 1'b0, 8'h40};
        vt[17] = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 4'h8, 1'b1, 8'h80};
        vt[18] = '{1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 4'h0, 1'b1, 8'h80};

        rst_n    = 1'b0;
        ce       = 1'b0;
        csr_a    = 5'd0;
        csr_di   = 8'h00;
        csr_we   = 1'b0;
        start    = 1'b0;
        pwr_good = 1'b1;
        step();
        step();
        chk("reset rst_out", {4'h0, rst_out}, 8'h0F);
        chk("reset done", {7'd0, done}, 8'h00);
        rst_n = 1'b1;
        step();
        rd("reset CTRL", 5'd0, 8'h00);
        rd("reset DELAY", 5'd1, 8'h10);
        rd("reset CMD", 5'd2, 8'h00);
        rd("unmapped addr 3", 5'd3, 8'h00);

        // Table: DELAY=2 full sequence, then restart with DELAY=1.
        for (int i = 0; i < 19; i++) begin
            ce     = vt[i].ce;
            start  = vt[i].start;
            csr_we = vt[i].we;
            csr_a  = vt[i].a;
            csr_di = vt[i].di;
            step();
            chk($sformatf("vec%0d rst_out", i), {4'h0, rst_out}, {4'h0, vt[i].rst});
            chk($sformatf("vec%0d done", i), {7'd0, done}, {7'd0, vt[i].done});
            chk($sformatf("vec%0d csr_do", i), csr_do, vt[i].dout);
        end
        ce     = 1'b0;
        start  = 1'b0;
        csr_we = 1'b0;

        // Hold on stage 2 through a sequence, then release it in DONE.
        do_reset();
        wr(5'd1, 8'h01);
        wr(5'd0, 8'h34);
        rd("hold upper bits dropped", 5'd0, 8'h04);
        pulse_start();
        ce = 1'b1;
        repeat (4) step();
        ce = 1'b0;
        step();
        chk("hold rst_out in DONE", {4'h0, rst_out}, 8'h04);
        chk("hold done", {7'd0, done}, 8'h01);
        rd("hold CTRL in DONE", 5'd0, 8'h84);
        wr(5'd0, 8'h00);
        chk("hold clear same edge", {4'h0, rst_out}, 8'h04);
        step();
        chk("hold clear next edge", {4'h0, rst_out}, 8'h00);

        // Power loss after stage 1 released, then recovery.
        wr(5'd2, 8'h01);
        ce = 1'b1;
        step();
        step();
        ce = 1'b0;
        step();
        chk("pwr pre-drop rst_out", {4'h0, rst_out}, 8'h0C);
        pwr_good = 1'b0;
        step();
        chk("pwr drop done", {7'd0, done}, 8'h00);
        chk("pwr drop rst_out edge", {4'h0, rst_out}, 8'h0C);
        rd("pwr drop CTRL idle", 5'd0, 8'h00);
        wr(5'd2, 8'h01);
        chk("pwr drop rst_out next", {4'h0, rst_out}, 8'h0F);
        rd("restart ignored pwr low", 5'd0, 8'h00);
        pwr_good = 1'b1;
        wr(5'd2, 8'h01);
        rd("restart ignored in IDLE", 5'd0, 8'h00);
        pulse_start();
        rd("rerun busy", 5'd0, 8'h40);
        ce = 1'b1;
        repeat (4) step();
        ce = 1'b0;
        step();
        chk("rerun rst_out", {4'h0, rst_out}, 8'h00);
        chk("rerun done", {7'd0, done}, 8'h01);

        // DELAY=0 acts as 1; start in WAIT is ignored.
        wr(5'd1, 8'h00);
        rd("DELAY reads 0", 5'd1, 8'h00);
        wr(5'd2, 8'h01);
        ce = 1'b1;
        step();
        ce = 1'b0;
        rd("delay0 idx after 1 tick", 5'd2, 8'h01);
        pulse_start();
        rd("start in WAIT idx", 5'd2, 8'h01);
        rd("start in WAIT busy", 5'd0, 8'h40);
        ce = 1'b1;
        repeat (3) step();
        ce = 1'b0;
        step();
        chk("delay0 done", {7'd0, done}, 8'h01);
        chk("delay0 rst_out", {4'h0, rst_out}, 8'h00);
        rd("idx in DONE", 5'd2, 8'h03);

        // Restart and ce in the same cycle: restart wins, count restarts.
        wr(5'd1, 8'h02);
        wr(5'd2, 8'h01);
        ce = 1'b1;
        step();
        csr_we = 1'b1;
        csr_a  = 5'd2;
        csr_di = 8'h01;
        step();
        csr_we = 1'b0;
        ce     = 1'b0;
        rd("restart+ce idx", 5'd2, 8'h00);
        chk("restart+ce rst_out", {4'h0, rst_out}, 8'h0F);
        ce = 1'b1;
        step();
        ce = 1'b0;
        rd("after restart 1 tick", 5'd2, 8'h00);
        ce = 1'b1;
        step();
        ce = 1'b0;
        rd("after restart 2 ticks", 5'd2, 8'h01);
        step();
        chk("after restart stage0", {4'h0, rst_out}, 8'h0E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged peripheral reset sequencer on the board CPLD's shared CSR bus. After a start pulse, with power good, it releases up to six active-high reset outputs one after another, separated by a programmable number of clock-enable ticks. The outputs drive the PCIe, USB hub, eDP bridge and GbE PHY reset pins. Software can hold any stage in reset, read progress, and re-run the sequence over I2C.

## Interface
- BASE_ADDR, 5'h0, CSR base; the block occupies BASE_ADDR..BASE_ADDR+2
- NUM_STAGES, 4, number of reset outputs; legal range 1..6
- DEFAULT_DELAY, 8'h10, reset value of the DELAY register, in ce ticks
- DEFAULT_HOLD, 6'b000000, reset value of the hold mask
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- ce  in  1  single-cycle tick enable (ce_8hz or ce_32khz from clockgen)
- csr_a  in  5  CSR address
- csr_di  in  8  CSR write data
- csr_we  in  1  CSR write strobe, one cycle
- csr_do  out  8  CSR read data; 8'h00 when the address is not ours (OR-bus)
- start  in  1  single-cycle pulse that begins the sequence
- pwr_good  in  1  level; low aborts the sequence and holds all stages in reset
- rst_out  out  NUM_STAGES  active-high reset per stage, registered
- done  out  1  high while in DONE

## Operation
- Registers:
  - CTRL at BASE_ADDR: [7] done (RO), [6] busy (RO), [5:0] hold mask (R/W). Hold bits at index NUM_STAGES and above read 0 and ignore writes.
  - DELAY at BASE_ADDR+1: R/W, 8 bits. A value of 0 is treated as 1.
  - CMD at BASE_ADDR+2: writing 1 to bit 0 requests a restart. Reads return {5'b0, idx[2:0]}.
- Internal state:
  - released[NUM_STAGES-1:0], the set of stages the FSM has released.
  - idx[2:0], the next stage to release.
  - cnt[7:0], the tick counter.
  - delay_q[7:0], DELAY latched when a sequence starts.
- Output equation: rst_out[i] <= ~released[i] | hold[i], registered.
- FSM states: IDLE, WAIT, DONE.
  - IDLE:
    - released=0, idx=0, cnt=0.
    - start & pwr_good -> WAIT; latch delay_q=max(DELAY,1).
  - WAIT, on each ce:
    - If cnt+1 == delay_q: set released[idx], cnt<=0.
    - Then if idx == NUM_STAGES-1 -> DONE, else idx<=idx+1.
    - Otherwise cnt<=cnt+1.
  - DONE: holds released=all ones.
- Transitions from any state:
  - pwr_good==0 -> IDLE, clearing released, idx and cnt.
  - Restart write in WAIT or DONE -> WAIT, clearing released, idx and cnt, and re-latching delay_q from DELAY.
- Priority, highest first: rst_n, pwr_good low, restart, start.
  - start in WAIT or DONE is ignored.
  - Restart in IDLE, or while pwr_good is low, is ignored.
- The hold mask acts at any time, including in IDLE and DONE. Clearing a hold bit on a stage that is already released deasserts that stage's reset.

## Timing
- Reset (rst_n=0 at a clk edge):
  - rst_out all ones, done 0, state IDLE.
  - DELAY=DEFAULT_DELAY, hold=DEFAULT_HOLD.
- csr_do is combinational from csr_a and register state, valid in the same cycle.
- CSR writes take effect on the next clk edge. A restart write produces the WAIT state one cycle later.
- Stage k (0-based) deasserts one clk after the (k+1)*delay_q-th ce following the cycle the sequence entered WAIT.
- done rises in the same cycle that the last stage's bit is set in released. rst_out follows one clk later.
- pwr_good falling causes rst_out to go all ones exactly one clk after the sampling edge.
- ce and csr_we in the same cycle: both are processed. A restart wins over the tick count.

## Structure
- Shared package:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
  - Register offsets CTRL=0, DELAY=1, CMD=2.
  - Bit positions DONE=7, BUSY=6, RESTART=0.
- One sub-module, stage_timer, is natural: the ce-gated 8-bit counter with clear, load and an expire pulse. The top level holds the FSM and the CSR decode.

## Test plan
- Reset, then start with pwr_good=1, DELAY=8'h02, NUM_STAGES=4 -> rst_out goes 1111, 1110, 1100, 1000, 0000 at ce counts 2, 4, 6, 8. CTRL reads 8'h80 after the last stage releases.
- hold=6'b000100 set before start, then cleared in DONE -> stage 2 stays asserted while the others release. Stage 2 deasserts one clk after the CTRL write.
- Drop pwr_good after stage 1 has released -> rst_out=1111 one clk later, state IDLE, done=0. A later start re-runs the full sequence.
- Write CMD=8'h01 in DONE with DELAY changed to 8'h01 -> all stages reassert, then release on consecutive ce ticks.
- DELAY=8'h00 -> behaves exactly as DELAY=8'h01. start during WAIT is ignored, and idx reads as expected through CMD.
- Read address BASE_ADDR+3 -> csr_do=8'h00. csr_we and ce in the same cycle as a restart -> the restart takes priority and cnt=0.
